// File: rtl/seven_seg_mux_ctrl.sv
// Bus-mapped multiplexed seven-segment controller: per-digit value registers, a control
// register (enable + 16-level brightness), a tick-prescaled scan/PWM engine and registered outputs.
module seven_seg_mux_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter logic [7:0]  BASE_ADDR  = 8'hD0,
    parameter int unsigned TICK_DIV   = 2500,
    parameter logic [7:0]  CTRL_RST   = 8'hF1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  BUS_WE,
    input  logic [7:0]            BUS_ADDR,
    input  logic [7:0]            BUS_DATA,
    output logic [NUM_DIGITS-1:0] SEL,
    output logic [7:0]            DIGIT
);

    localparam int unsigned DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // Active-low a..g pattern for one hex nibble, returned as [6:0] = g..a.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    state_t          state_r, state_s;
    logic [PW-1:0]   presc_r, presc_s;
    logic [3:0]      t_cnt_r, t_cnt_s;
    logic [DW-1:0]   dig_idx_r, dig_idx_s;
    logic [7:0]      ctrl_r;
    logic [7:0]      digit_regs_r [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] sel_r, sel_s;
    logic [7:0]      digit_r, digit_s;

    logic            run_s;
    logic            tick_s;
    logic [8:0]      addr_off_s;
    logic            wr_en_s;
    logic [7:0]      cur_digit_s;
    logic            lit_s;
    logic            unused_bits_s;

    // Address window decode; a borrow in bit 8 means the address lies below the window.
    always_comb begin
        addr_off_s = {1'b0, BUS_ADDR} - {1'b0, BASE_ADDR};
        wr_en_s    = BUS_WE && !addr_off_s[8] && (addr_off_s[7:0] <= 8'(NUM_DIGITS));
    end

    // Scan FSM: counters only run while scanning with enable still set.
    always_comb begin
        state_s = state_r;
        run_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ctrl_r[0]) begin
                    state_s = ST_SCAN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (ctrl_r[0]) begin
                    state_s = ST_SCAN;
                    run_s   = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Prescaler, PWM tick counter and digit index; cleared whenever not running.
    always_comb begin
        tick_s    = (presc_r == PW'(TICK_DIV - 1));
        presc_s   = {PW{1'b0}};
        t_cnt_s   = 4'd0;
        dig_idx_s = {DW{1'b0}};
        if (run_s) begin
            presc_s   = tick_s ? {PW{1'b0}} : presc_r + PW'(1);
            t_cnt_s   = tick_s ? t_cnt_r + 4'd1 : t_cnt_r;
            dig_idx_s = dig_idx_r;
            if (tick_s && (t_cnt_r == 4'd15)) begin
                dig_idx_s = (dig_idx_r == DW'(NUM_DIGITS - 1)) ? {DW{1'b0}} : dig_idx_r + DW'(1);
            end else begin
                dig_idx_s = dig_idx_r;
            end
        end else begin
            presc_s = {PW{1'b0}};
        end
    end

    // Next anode/cathode pattern; enable is checked directly so a disable darkens one cycle later.
    always_comb begin
        cur_digit_s = digit_regs_r[dig_idx_r];
        lit_s       = (state_r == ST_SCAN) && ctrl_r[0] &&
                      (t_cnt_r < ctrl_r[7:4]) && !cur_digit_s[5];
        sel_s       = {NUM_DIGITS{1'b1}};
        digit_s     = 8'hFF;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            sel_s[k] = ~(lit_s && (dig_idx_r == DW'(k)));
        end
        if (lit_s) begin
            digit_s = {~cur_digit_s[4], seg_decode(cur_digit_s[3:0])};
        end else begin
            digit_s = 8'hFF;
        end
        unused_bits_s = ^{cur_digit_s[7:6], ctrl_r[3:1]};
    end

    // State, counters, bus registers and output registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r   <= ST_IDLE;
            presc_r   <= {PW{1'b0}};
            t_cnt_r   <= 4'd0;
            dig_idx_r <= {DW{1'b0}};
            ctrl_r    <= CTRL_RST;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                digit_regs_r[k] <= 8'h00;
            end
            sel_r     <= {NUM_DIGITS{1'b1}};
            digit_r   <= 8'hFF;
        end else begin
            state_r   <= state_s;
            presc_r   <= presc_s;
            t_cnt_r   <= t_cnt_s;
            dig_idx_r <= dig_idx_s;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (wr_en_s && (addr_off_s == 9'(k))) begin
                    digit_regs_r[k] <= BUS_DATA;
                end
            end
            if (wr_en_s && (addr_off_s == 9'(NUM_DIGITS))) begin
                ctrl_r <= BUS_DATA;
            end
            sel_r     <= sel_s;
            digit_r   <= digit_s;
        end
    end

    assign SEL   = sel_r;
    assign DIGIT = digit_r;

endmodule

// File: tb/tb_seven_seg_mux_ctrl.sv
// Directed bench for seven_seg_mux_ctrl (4 digits, TICK_DIV=4); j counts output cycles from
// the first lit sample after a scan (re)start, so each digit slot spans 64 values of j.
module tb_seven_seg_mux_ctrl;

    logic       CLK;
    logic       RESET;
    logic       BUS_WE;
    logic [7:0] BUS_ADDR;
    logic [7:0] BUS_DATA;
    logic [3:0] SEL;
    logic [7:0] DIGIT;

    int n_tests;
    int n_fail;
    int j_now;

    seven_seg_mux_ctrl #(
        .NUM_DIGITS(4),
        .BASE_ADDR (8'hD0),
        .TICK_DIV  (4),
        .CTRL_RST  (8'hF1)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .BUS_WE  (BUS_WE),
        .BUS_ADDR(BUS_ADDR),
        .BUS_DATA(BUS_DATA),
        .SEL     (SEL),
        .DIGIT   (DIGIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic bus_write(input logic we, input logic [7:0] a, input logic [7:0] d);
        BUS_WE   = we;
        BUS_ADDR = a;
        BUS_DATA = d;
        @(posedge CLK);
        #1;
        BUS_WE   = 1'b0;
        j_now++;
    endtask

    task automatic adv_to(input int target);
        while (j_now < target) begin
            @(posedge CLK);
            #1;
            j_now++;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] exp_sel, input logic [7:0] exp_dig);
        n_tests++;
        assert (SEL === exp_sel && DIGIT === exp_dig) else begin
            n_fail++;
            $error("FAIL %s (j=%0d): SEL=%b DIGIT=%h, expected SEL=%b DIGIT=%h",
                   tag, j_now, SEL, DIGIT, exp_sel, exp_dig);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        j_now    = 0;
        RESET    = 1'b1;
        BUS_WE   = 1'b0;
        BUS_ADDR = 8'h00;
        BUS_DATA = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_state", 4'b1111, 8'hFF);
        RESET = 1'b0;

        // Pause scanning, load digits 1..4, then enable with full brightness.
        bus_write(1'b1, 8'hD4, 8'hF0);
        bus_write(1'b1, 8'hD0, 8'h01);
        chk("disabled_dark", 4'b1111, 8'hFF);
        bus_write(1'b1, 8'hD1, 8'h02);
        bus_write(1'b1, 8'hD2, 8'h03);
        bus_write(1'b1, 8'hD3, 8'h04);
        bus_write(1'b1, 8'hD4, 8'hF1);
        j_now = -2;
        adv_to(-1);
        chk("start_latency", 4'b1111, 8'hFF);
        adv_to(0);    chk("d0_first",  4'b1110, 8'hF9);
        adv_to(59);   chk("d0_last",   4'b1110, 8'hF9);
        adv_to(60);   chk("d0_guard",  4'b1111, 8'hFF);
        adv_to(64);   chk("d1_first",  4'b1101, 8'hA4);
        adv_to(128);  chk("d2_first",  4'b1011, 8'hB0);
        adv_to(192);  chk("d3_first",  4'b0111, 8'h99);
        adv_to(255);  chk("d3_guard",  4'b1111, 8'hFF);
        adv_to(256);  chk("d0_wrap",   4'b1110, 8'hF9);

        // Brightness 4: lit for t=0..3 only.
        adv_to(319);
        bus_write(1'b1, 8'hD4, 8'h41);
        adv_to(335);  chk("b4_d1_lit",   4'b1101, 8'hA4);
        adv_to(336);  chk("b4_d1_dark",  4'b1111, 8'hFF);
        adv_to(384);  chk("b4_d2_lit",   4'b1011, 8'hB0);
        adv_to(399);  chk("b4_d2_last",  4'b1011, 8'hB0);
        adv_to(400);  chk("b4_d2_dark",  4'b1111, 8'hFF);

        // Blank digit 2, then show 8 with dp.
        bus_write(1'b1, 8'hD2, 8'h30);
        adv_to(576);  chk("blank_d1_ok", 4'b1101, 8'hA4);
        adv_to(640);  chk("blank_d2",    4'b1111, 8'hFF);
        adv_to(700);
        bus_write(1'b1, 8'hD2, 8'h18);
        adv_to(896);  chk("d2_eight_dp", 4'b1011, 8'h00);
        adv_to(911);  chk("d2_eight_end", 4'b1011, 8'h00);
        adv_to(912);  chk("d2_eight_off", 4'b1111, 8'hFF);

        // Disable mid-slot, then re-enable.
        adv_to(960);  chk("d3_before_dis", 4'b0111, 8'h99);
        bus_write(1'b1, 8'hD4, 8'hF0);
        adv_to(962);  chk("disable_1cyc", 4'b1111, 8'hFF);
        adv_to(970);  chk("disable_hold", 4'b1111, 8'hFF);
        bus_write(1'b1, 8'hD4, 8'hF1);
        j_now = -2;
        adv_to(-1);   chk("reen_latency", 4'b1111, 8'hFF);
        adv_to(0);    chk("reen_d0",      4'b1110, 8'hF9);
        adv_to(59);   chk("reen_d0_b15",  4'b1110, 8'hF9);
        adv_to(64);   chk("reen_d1",      4'b1101, 8'hA4);

        // Out-of-window writes and a write with BUS_WE low.
        bus_write(1'b1, 8'hD5, 8'h00);
        bus_write(1'b1, 8'hCF, 8'h05);
        bus_write(1'b0, 8'hD1, 8'h08);
        bus_write(1'b0, 8'hD4, 8'h00);
        adv_to(144);  chk("ign_d2",  4'b1011, 8'h00);
        adv_to(200);  chk("ign_d3",  4'b0111, 8'h99);
        adv_to(256);  chk("ign_d0",  4'b1110, 8'hF9);
        adv_to(320);  chk("ign_d1",  4'b1101, 8'hA4);

        // One-cycle reset mid-scan.
        adv_to(330);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        chk("midreset_dark", 4'b1111, 8'hFF);
        j_now = -2;
        adv_to(-1);   chk("post_reset_lat", 4'b1111, 8'hFF);
        adv_to(0);    chk("post_reset_d0",  4'b1110, 8'hC0);
        adv_to(64);   chk("post_reset_d1",  4'b1101, 8'hC0);
        adv_to(128);  chk("post_reset_d2",  4'b1011, 8'hC0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
